// File: rtl/ifmap_req_arbiter.sv
// Input-feature-map row server: broadcasts the first row of each PPE, then serves
// per-PPE row requests round-robin, for two timesteps, packing rows into router packets.
module ifmap_req_arbiter #(
    parameter int IFMAP_SIZE   = 25,
    parameter int NUM_PE       = 5,
    parameter int FIRST_PE_ID  = 5,
    parameter int OP_PPE_INPUT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ts_done,
    input  logic [NUM_PE-1:0]     req,
    output logic [NUM_PE-1:0]     ack,
    output logic                  mem_rd_en,
    output logic [4:0]            mem_rd_row,
    output logic                  mem_ts,
    input  logic [IFMAP_SIZE-1:0] mem_rd_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [IFMAP_SIZE+7:0] pkt_data,
    output logic                  done,
    output logic                  err_overrun
);
    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CW = $clog2(IFMAP_SIZE + 1);

    typedef enum logic [2:0] {IDLE, BCAST_RD, BCAST_SEND, ARB, RD, SEND, DONE} state_t;

    state_t                 r_state;
    logic                   r_ts;
    logic [NUM_PE-1:0][5:0] r_ptr;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_rr;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          r_g;
    logic [NUM_PE-1:0]      r_ack_ovr;

    logic                   w_start_acc;
    logic                   w_ts_acc;
    logic                   w_gnt_vld;
    logic [IW-1:0]          w_gnt;
    logic [IW-1:0]          w_sel;
    logic [3:0]             w_dest;
    logic [NUM_PE-1:0]      w_ack_hs;
    logic                   w_last_row;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'((v >= NUM_PE) ? v - NUM_PE : v);
    endfunction

    assign w_start_acc = start && (r_state == IDLE || r_state == DONE);
    assign w_ts_acc    = !w_start_acc && ts_done && !r_ts && (r_state == ARB || r_state == DONE);

    // Search from the requester after the last grant; lowest offset wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (req[wrap(int'(r_rr) + k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = wrap(int'(r_rr) + k);
            end
        end
    end

    assign w_sel      = (r_state == BCAST_SEND) ? r_idx : r_g;
    assign w_dest     = 4'(FIRST_PE_ID) + 4'(w_sel);
    assign w_last_row = (r_cnt + 1'b1) == CW'(IFMAP_SIZE);
    // The grant-complete pulse must coincide with the handshake cycle itself.
    assign w_ack_hs   = (r_state == SEND && pkt_valid && pkt_ready) ? (NUM_PE'(1) << r_g) : '0;
    assign ack        = w_ack_hs | r_ack_ovr;
    assign mem_ts     = r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ts        <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_rr        <= '0;
            r_idx       <= '0;
            r_g         <= '0;
            r_ack_ovr   <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_row  <= '0;
            pkt_valid   <= 1'b0;
            pkt_data    <= '0;
            done        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            r_ack_ovr <= '0;
            mem_rd_en <= 1'b0;
            if (w_start_acc || w_ts_acc) begin
                r_ts  <= w_ts_acc;
                r_cnt <= '0;
                r_idx <= '0;
                done  <= 1'b0;
                for (int i = 0; i < NUM_PE; i++) r_ptr[i] <= 6'(i);
                mem_rd_en  <= 1'b1;
                mem_rd_row <= '0;
                r_state    <= BCAST_RD;
            end else begin
                case (r_state)
                    BCAST_RD: r_state <= BCAST_SEND;
                    RD:       r_state <= SEND;
                    BCAST_SEND, SEND: begin
                        // First cycle captures the row read in the previous cycle.
                        if (!pkt_valid) begin
                            pkt_valid <= 1'b1;
                            pkt_data  <= {w_dest, 4'(OP_PPE_INPUT), mem_rd_data};
                        end else if (pkt_ready) begin
                            pkt_valid    <= 1'b0;
                            r_ptr[w_sel] <= r_ptr[w_sel] + 6'(NUM_PE);
                            r_cnt        <= r_cnt + 1'b1;
                            if (w_last_row) begin
                                done    <= 1'b1;
                                r_state <= DONE;
                            end else if (r_state == BCAST_SEND && int'(r_idx) < NUM_PE - 1) begin
                                r_idx      <= r_idx + 1'b1;
                                mem_rd_en  <= 1'b1;
                                mem_rd_row <= 5'(r_idx + 1'b1);
                                r_state    <= BCAST_RD;
                            end else begin
                                r_state <= ARB;
                            end
                        end
                    end
                    ARB: begin
                        if (w_gnt_vld) begin
                            r_rr <= wrap(int'(w_gnt) + 1);
                            if (r_ptr[w_gnt] < 6'(IFMAP_SIZE)) begin
                                r_g        <= w_gnt;
                                mem_rd_en  <= 1'b1;
                                mem_rd_row <= r_ptr[w_gnt][4:0];
                                r_state    <= RD;
                            end else begin
                                r_ack_ovr[w_gnt] <= 1'b1;
                                err_overrun      <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifmap_req_arbiter.sv
// Directed bench for ifmap_req_arbiter: broadcast, round-robin service, back-pressure,
// overrun, timestep switch and asynchronous reset, against a simple row memory model.
module tb_ifmap_req_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, ts_done, pkt_ready;
    logic [4:0]  req, ack;
    logic        mem_rd_en, mem_ts, pkt_valid, done, err_overrun;
    logic [4:0]  mem_rd_row;
    logic [24:0] mem_rd_data;
    logic [32:0] pkt_data;

    int npass = 0;
    int ntot  = 0;
    int rd_cnt = 0;
    int ack_cnt = 0;

    ifmap_req_arbiter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ts_done(ts_done), .req(req), .ack(ack),
        .mem_rd_en(mem_rd_en), .mem_rd_row(mem_rd_row), .mem_ts(mem_ts),
        .mem_rd_data(mem_rd_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .done(done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] pat(input logic t, input logic [4:0] r);
        return (25'(r) * 25'h004C3B + 25'h15) ^ (t ? 25'h1A5A5A5 : 25'h0);
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rd_data <= pat(mem_ts, mem_rd_row);
            rd_cnt      <= rd_cnt + 1;
        end
        if (|ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_pkt(input string tag, input int dest, input int row, input logic t,
                              input logic [4:0] eack);
        for (int c = 0; c < 40; c++) begin
            step();
            if (pkt_valid === 1'b1) break;
        end
        chk({tag, "_vld"}, 64'(pkt_valid), 64'd1);
        chk({tag, "_data"}, 64'(pkt_data), 64'({4'(dest), 4'd1, pat(t, 5'(row))}));
        chk({tag, "_ack"}, 64'(ack), 64'(eack));
    endtask

    initial begin
        logic [32:0] held;
        int          snap;
        rst_n = 1'b0; start = 1'b0; ts_done = 1'b0; req = '0; pkt_ready = 1'b1;
        step(); step();
        chk("rst_ack", 64'(ack), 0);
        chk("rst_rden", 64'(mem_rd_en), 0);
        chk("rst_row", 64'(mem_rd_row), 0);
        chk("rst_ts", 64'(mem_ts), 0);
        chk("rst_pv", 64'(pkt_valid), 0);
        chk("rst_pd", 64'(pkt_data), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err_overrun), 0);
        rst_n = 1'b1;
        step();

        // Timestep 1 broadcast: rows 0..4 to PPEs 5..9, no acks
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) expect_pkt($sformatf("bc%0d", i), 5 + i, i, 1'b0, 5'b0);
        step(); step(); step();
        chk("bc_noack", 64'(ack_cnt), 0);
        chk("bc_rdcnt", 64'(rd_cnt), 5);
        chk("arb_idle_rd", 64'(mem_rd_en), 0);

        // First grant with 4 cycles of back-pressure
        pkt_ready = 1'b0; req = 5'b11111;
        expect_pkt("stall", 5, 5, 1'b0, 5'b0);
        held = pkt_data;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("stall_hold%0d", k), 64'(pkt_data), 64'(held));
            chk($sformatf("stall_ack%0d", k), 64'(ack), 0);
        end
        pkt_ready = 1'b1;
        #1;
        chk("stall_release_ack", 64'(ack), 64'(5'b00001));

        // Round-robin over all five requesters for rows 6..24
        for (int r = 6; r < 25; r++)
            expect_pkt($sformatf("rr%0d", r), 5 + (r % 5), r, 1'b0, 5'(1 << (r % 5)));
        chk("done_before_last", 64'(done), 0);
        step();
        chk("done_ts1", 64'(done), 1);
        chk("ack_cnt_ts1", 64'(ack_cnt), 20);
        req = '0;
        step();
        chk("done_hold", 64'(done), 1);

        // Timestep 2 broadcast; a second ts_done mid-broadcast must be ignored
        ts_done = 1'b1; step(); ts_done = 1'b0;
        chk("ts2_memts", 64'(mem_ts), 1);
        chk("ts2_done_clr", 64'(done), 0);
        expect_pkt("ts2bc0", 5, 0, 1'b1, 5'b0);
        expect_pkt("ts2bc1", 6, 1, 1'b1, 5'b0);
        ts_done = 1'b1; step(); ts_done = 1'b0;
        for (int i = 2; i < 5; i++) expect_pkt($sformatf("ts2bc%0d", i), 5 + i, i, 1'b1, 5'b0);
        step();
        ts_done = 1'b1; step(); ts_done = 1'b0;

        // PPE 5 alone takes rows 5,10,15,20, then overruns
        req = 5'b00001;
        for (int r = 5; r <= 20; r += 5) expect_pkt($sformatf("p5_%0d", r), 5, r, 1'b1, 5'b00001);
        snap = rd_cnt;
        step(); step();
        chk("ovr_ack", 64'(ack), 64'(5'b00001));
        chk("ovr_err", 64'(err_overrun), 1);
        req = '0;
        step();
        chk("ovr_ack_clr", 64'(ack), 0);
        chk("ovr_noread", 64'(rd_cnt), 64'(snap));
        chk("ovr_sticky", 64'(err_overrun), 1);

        // Asynchronous reset mid-packet
        pkt_ready = 1'b0; req = 5'b00010;
        expect_pkt("rstpkt", 6, 6, 1'b1, 5'b0);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pv", 64'(pkt_valid), 0);
        chk("arst_pd", 64'(pkt_data), 0);
        chk("arst_err", 64'(err_overrun), 0);
        chk("arst_ts", 64'(mem_ts), 0);
        chk("arst_ack", 64'(ack), 0);
        step(); step();
        rst_n = 1'b1; pkt_ready = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        expect_pkt("restart", 5, 0, 1'b0, 5'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
